// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HI
   } rx_state_e;

   function automatic int calcDiv(input int clkHz, input int baud);
      return clkHz / baud;
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic [DATA_WIDTH-1:0]   pushData_i,
   input  logic                    pop_i,
   output logic [DATA_WIDTH-1:0]   rdData_o,
   output logic                    empty_o,
   output logic                    full_o,
   output logic [clog2(DEPTH):0]   count_o
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wrPtr_q;
   logic [AW-1:0]         rdPtr_q;
   logic [AW:0]           count_q;
   logic                  doPush;
   logic                  doPop;

   assign full_o   = (count_q == DEPTH_C);
   assign empty_o  = (count_q == '0);
   assign doPop    = pop_i && !empty_o;
   assign doPush   = push_i && (!full_o || doPop);
   assign count_o  = count_q;
   assign rdData_o = empty_o ? '0 : mem_q[rdPtr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the pointers and count decide what is visible.
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= pushData_i;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchroniser, oversampling frame FSM, byte FIFO, last-byte register and activity timer.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int          CLK_HZ      = 100_000_000,
   parameter int          BAUD        = 9600,
   parameter int          DATA_BITS   = 8,
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [31:0] HOLD_CYCLES = 32'h007F_FFFF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         rxd,
   input  logic                         rd_en,
   output logic [DATA_BITS-1:0]         rd_data,
   output logic                         empty,
   output logic                         full,
   output logic [clog2(FIFO_DEPTH):0]   count,
   output logic [DATA_BITS-1:0]         word,
   output logic                         active,
   output logic                         frame_err,
   output logic                         overrun
);

   localparam int          DIV      = calcDiv(CLK_HZ, BAUD);
   localparam logic [31:0] DIV_FULL = 32'(DIV - 1);
   localparam logic [31:0] DIV_HALF = 32'(DIV / 2 - 1);
   localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

   logic                 rxMeta_q;
   logic                 rxs_q;
   rx_state_e            state_q, state_d;
   logic [31:0]          cntDiv_q, cntDiv_d;
   logic [3:0]           cntBit_q, cntBit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] word_q;
   logic [31:0]          actCnt_q;
   logic                 frameErr_q, frameErr_d;
   logic                 overrun_q, overrun_d;
   logic                 push;

   always_ff @(posedge clk) begin
      if (reset) begin
         rxMeta_q <= 1'b1;
         rxs_q    <= 1'b1;
      end else begin
         rxMeta_q <= rxd;
         rxs_q    <= rxMeta_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      cntDiv_d   = cntDiv_q;
      cntBit_d   = cntBit_q;
      shreg_d    = shreg_q;
      push       = 1'b0;
      frameErr_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxs_q) begin
               state_d  = START;
               cntDiv_d = DIV_HALF;
            end
         end
         START: begin
            if (cntDiv_q != '0) begin
               cntDiv_d = cntDiv_q - 1'b1;
            end else if (rxs_q) begin
               state_d = IDLE;
            end else begin
               state_d  = DATA;
               cntDiv_d = DIV_FULL;
               cntBit_d = '0;
            end
         end
         DATA: begin
            if (cntDiv_q != '0) begin
               cntDiv_d = cntDiv_q - 1'b1;
            end else begin
               shreg_d  = {rxs_q, shreg_q[DATA_BITS-1:1]};
               cntDiv_d = DIV_FULL;
               cntBit_d = cntBit_q + 1'b1;
               if (cntBit_q == LAST_BIT) state_d = STOP;
            end
         end
         STOP: begin
            if (cntDiv_q != '0) begin
               cntDiv_d = cntDiv_q - 1'b1;
            end else if (rxs_q) begin
               push    = 1'b1;
               state_d = IDLE;
            end else begin
               frameErr_d = 1'b1;
               state_d    = WAIT_HI;
            end
         end
         // A line held low after a bad stop bit must go high before a new start is trusted.
         WAIT_HI: begin
            if (rxs_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign overrun_d = push && full && !rd_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cntDiv_q   <= '0;
         cntBit_q   <= '0;
         shreg_q    <= '0;
         word_q     <= '0;
         actCnt_q   <= '0;
         frameErr_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cntDiv_q   <= cntDiv_d;
         cntBit_q   <= cntBit_d;
         shreg_q    <= shreg_d;
         frameErr_q <= frameErr_d;
         overrun_q  <= overrun_d;
         if (push) begin
            word_q   <= shreg_q;
            actCnt_q <= HOLD_CYCLES;
         end else if (actCnt_q != '0) begin
            actCnt_q <= actCnt_q - 1'b1;
         end
      end
   end

   uart_byte_fifo #(
      .DATA_WIDTH (DATA_BITS),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push),
      .pushData_i (shreg_q),
      .pop_i      (rd_en),
      .rdData_o   (rd_data),
      .empty_o    (empty),
      .full_o     (full),
      .count_o    (count)
   );

   assign word      = word_q;
   assign active    = |actCnt_q;
   assign frame_err = frameErr_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with DIV=16, HOLD_CYCLES=100, FIFO_DEPTH=4.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxd;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [2:0] count;
   logic [7:0] word;
   logic       active;
   logic       frame_err;
   logic       overrun;

   int checks   = 0;
   int failures = 0;
   int feHigh   = 0;
   int fePulses = 0;
   int ovHigh   = 0;
   int ovPulses = 0;
   logic fePrev = 1'b0;
   logic ovPrev = 1'b0;

   uart_rx_fifo #(
      .CLK_HZ      (1_600_000),
      .BAUD        (100_000),
      .DATA_BITS   (8),
      .FIFO_DEPTH  (4),
      .HOLD_CYCLES (32'd100)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .word      (word),
      .active    (active),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Pulse counters: high cycles must equal rising edges for a true 1-cycle pulse.
   always @(negedge clk) begin
      if (frame_err === 1'b1) begin
         feHigh++;
         if (!fePrev) fePulses++;
      end
      if (overrun === 1'b1) begin
         ovHigh++;
         if (!ovPrev) ovPulses++;
      end
      fePrev = (frame_err === 1'b1);
      ovPrev = (overrun === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopVal);
      rxd = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(16);
      end
      rxd = stopVal;
      tick(16);
   endtask

   task automatic test_reset;
      reset = 1'b1; rxd = 1'b1; rd_en = 1'b0;
      tick(3);
      checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
      checks++; if (rd_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rd_data got=%h exp=00", rd_data); end
      checks++; if (word !== 8'h00) begin failures++; $display("[TB] FAIL reset_word got=%h exp=00", word); end
      checks++; if ({active, frame_err, overrun} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=000", {active, frame_err, overrun}); end
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_single_byte;
      int n;
      fork
         sendFrame(8'h55, 1'b1);
         begin
            n = 0;
            while (count === 3'd0 && n < 400) begin tick(1); n++; end
            checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=1", count); end
            checks++; if (word !== 8'h55) begin failures++; $display("[TB] FAIL single_word got=%h exp=55", word); end
            checks++; if (rd_data !== 8'h55) begin failures++; $display("[TB] FAIL single_rd_data got=%h exp=55", rd_data); end
            checks++; if (active !== 1'b1) begin failures++; $display("[TB] FAIL single_active got=%b exp=1", active); end
            n = 0;
            while (active === 1'b1 && n < 300) begin tick(1); n++; end
            checks++; if (n != 100) begin failures++; $display("[TB] FAIL active_hold got=%0d exp=100", n); end
         end
      join
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      checks++; if (empty !== 1'b1 || count !== 3'd0) begin failures++; $display("[TB] FAIL pop_to_empty got=%b/%0d exp=1/0", empty, count); end
      rd_en = 1'b1; tick(2); rd_en = 1'b0;
      checks++; if (empty !== 1'b1 || count !== 3'd0 || rd_data !== 8'h00) begin failures++; $display("[TB] FAIL pop_while_empty got=%b/%0d/%h exp=1/0/00", empty, count, rd_data); end
   endtask

   task automatic test_glitch;
      int fe0;
      fe0 = fePulses;
      rxd = 1'b0; tick(4);
      rxd = 1'b1; tick(40);
      checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL glitch_count got=%0d exp=0", count); end
      checks++; if (fePulses != fe0) begin failures++; $display("[TB] FAIL glitch_frame_err got=%0d exp=0", fePulses - fe0); end
      checks++; if (word !== 8'h55) begin failures++; $display("[TB] FAIL glitch_word got=%h exp=55", word); end
   endtask

   task automatic test_frame_error;
      int fe0, feH0;
      fe0 = fePulses; feH0 = feHigh;
      sendFrame(8'hA3, 1'b0);
      tick(50);
      checks++; if (fePulses - fe0 != 1) begin failures++; $display("[TB] FAIL ferr_pulses got=%0d exp=1", fePulses - fe0); end
      checks++; if (feHigh - feH0 != 1) begin failures++; $display("[TB] FAIL ferr_width got=%0d exp=1", feHigh - feH0); end
      checks++; if (count !== 3'd0 || word !== 8'h55) begin failures++; $display("[TB] FAIL ferr_dropped got=%0d/%h exp=0/55", count, word); end
      rxd = 1'b1; tick(32);
      sendFrame(8'h11, 1'b1);
      tick(20);
      checks++; if (fePulses - fe0 != 1) begin failures++; $display("[TB] FAIL break_false_start got=%0d exp=1", fePulses - fe0); end
      checks++; if (count !== 3'd1 || rd_data !== 8'h11 || word !== 8'h11) begin failures++; $display("[TB] FAIL after_break got=%0d/%h/%h exp=1/11/11", count, rd_data, word); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
   endtask

   task automatic test_overrun;
      int ov0, ovH0;
      ov0 = ovPulses; ovH0 = ovHigh;
      for (int b = 1; b <= 4; b++) begin
         sendFrame(8'(b), 1'b1);
         tick(20);
         checks++; if (count !== 3'(b)) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=%0d", count, b); end
         checks++; if (full !== (b == 4)) begin failures++; $display("[TB] FAIL fill_full got=%b exp=%b", full, (b == 4)); end
      end
      sendFrame(8'h05, 1'b1);
      tick(20);
      checks++; if (ovPulses - ov0 != 1 || ovHigh - ovH0 != 1) begin failures++; $display("[TB] FAIL overrun_pulse got=%0d/%0d exp=1/1", ovPulses - ov0, ovHigh - ovH0); end
      checks++; if (word !== 8'h05) begin failures++; $display("[TB] FAIL overrun_word got=%h exp=05", word); end
      checks++; if (rd_data !== 8'h01 || count !== 3'd4) begin failures++; $display("[TB] FAIL overrun_head got=%h/%0d exp=01/4", rd_data, count); end
   endtask

   task automatic test_back_to_back;
      int ov0;
      logic [7:0] expQ [4];
      expQ = '{8'h02, 8'h03, 8'h04, 8'h06};
      ov0 = ovPulses;
      fork
         sendFrame(8'h06, 1'b1);
         begin
            tick(154);
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
         end
      join
      tick(20);
      checks++; if (count !== 3'd4 || full !== 1'b1) begin failures++; $display("[TB] FAIL pushpop_count got=%0d/%b exp=4/1", count, full); end
      checks++; if (ovPulses != ov0) begin failures++; $display("[TB] FAIL pushpop_overrun got=%0d exp=0", ovPulses - ov0); end
      checks++; if (rd_data !== 8'h02 || word !== 8'h06) begin failures++; $display("[TB] FAIL pushpop_data got=%h/%h exp=02/06", rd_data, word); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (rd_data !== expQ[i]) begin failures++; $display("[TB] FAIL drain_data got=%h exp=%h", rd_data, expQ[i]); end
         rd_en = 1'b1; tick(1); rd_en = 1'b0;
      end
      checks++; if (empty !== 1'b1 || count !== 3'd0) begin failures++; $display("[TB] FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
   endtask

   task automatic test_reset_mid_frame;
      int fe0;
      fe0 = fePulses;
      rxd = 1'b0; tick(16);
      rxd = 1'b0; tick(16);
      rxd = 1'b1; tick(16);
      rxd = 1'b1; tick(16);
      reset = 1'b1; rxd = 1'b1;
      tick(2);
      reset = 1'b0;
      checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("[TB] FAIL midreset_fifo got=%0d/%b/%b exp=0/1/0", count, empty, full); end
      checks++; if (word !== 8'h00 || rd_data !== 8'h00) begin failures++; $display("[TB] FAIL midreset_data got=%h/%h exp=00/00", word, rd_data); end
      checks++; if ({active, frame_err, overrun} !== 3'b000) begin failures++; $display("[TB] FAIL midreset_flags got=%b exp=000", {active, frame_err, overrun}); end
      tick(40);
      checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL midreset_no_push got=%0d exp=0", count); end
      sendFrame(8'h3C, 1'b1);
      tick(20);
      checks++; if (count !== 3'd1 || rd_data !== 8'h3C || word !== 8'h3C) begin failures++; $display("[TB] FAIL after_reset_frame got=%0d/%h/%h exp=1/3c/3c", count, rd_data, word); end
      checks++; if (fePulses != fe0) begin failures++; $display("[TB] FAIL after_reset_ferr got=%0d exp=0", fePulses - fe0); end
   endtask

   initial begin
      test_reset;
      test_single_byte;
      test_glitch;
      test_frame_error;
      test_overrun;
      test_back_to_back;
      test_reset_mid_frame;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
